// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with writeback bypass, load-use stall, flush and stall counter
module idex_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]  id_reg1,
    input  logic [DATA_W-1:0]  id_reg2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [7:0]         id_ctrl,
    input  logic               wb_regwrite,
    input  logic [RADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    output logic               ex_valid,
    output logic [RADDR_W-1:0] ex_rs,
    output logic [RADDR_W-1:0] ex_rt,
    output logic [RADDR_W-1:0] ex_dest,
    output logic [DATA_W-1:0]  ex_a,
    output logic [DATA_W-1:0]  ex_b,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [7:0]         ex_ctrl,
    output logic               stall,
    output logic [CNT_W-1:0]   stall_count
);
    logic [DATA_W-1:0] a_sel, b_sel;
    logic hz;
    // a zero source field never bypasses, so wb_reg == 0 cannot match here
    always_comb begin
        a_sel = (id_rs == '0) ? '0 : (wb_regwrite && wb_reg == id_rs) ? wb_data : id_reg1;
        b_sel = (id_rt == '0) ? '0 : (wb_regwrite && wb_reg == id_rt) ? wb_data : id_reg2;
        hz    = id_valid && ex_valid && ex_ctrl[1] && ex_dest != '0 &&
                (ex_dest == id_rs || ex_dest == id_rt);
        stall = hz && !flush;
    end
    always_ff @(posedge clk) begin
        if (reset || flush || stall) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_dest  <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_dest  <= id_ctrl[4] ? id_rd : id_rt;
            ex_a     <= a_sel;
            ex_b     <= b_sel;
            ex_imm   <= id_imm;
            ex_ctrl  <= id_valid ? id_ctrl : 8'h00;
        end
        if (reset)
            stall_count <= '0;
        else if (stall && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end
endmodule

// File: tb/tb_idex_stage.sv
// tb_idex_stage: directed-vector bench for idex_stage, built with a 4-bit stall counter
module tb_idex_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_reg1, id_reg2, id_imm;
    logic [7:0]  id_ctrl;
    logic        wb_regwrite;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [7:0]  ex_ctrl;
    logic        stall;
    logic [3:0]  stall_count;
    int n_checks = 0;
    int n_fail = 0;

    idex_stage #(.DATA_W(32), .RADDR_W(5), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg1(id_reg1), .id_reg2(id_reg2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_regwrite(wb_regwrite), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [7:0] ctrl);
        id_valid = 1'b1;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_reg1 = r1; id_reg2 = r2; id_ctrl = ctrl;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_reg1 = '0; id_reg2 = '0; id_imm = '0; id_ctrl = '0;
        wb_regwrite = 1'b0; wb_reg = '0; wb_data = '0;
        tick();
        reset = 1'b0;
        check("rst_valid", ex_valid, 0);
        check("rst_a", ex_a, 0);
        check("rst_ctrl", ex_ctrl, 0);
        check("rst_count", stall_count, 0);
        check("rst_stall", stall, 0);

        set_id(5'd8, 5'd9, 5'd10, 32'd2, 32'd4, 8'h11);
        id_imm = 32'h10;
        tick();
        check("cap_a", ex_a, 2);
        check("cap_b", ex_b, 4);
        check("cap_dest", ex_dest, 10);
        check("cap_ctrl", ex_ctrl, 8'h11);
        check("cap_valid", ex_valid, 1);
        check("cap_imm", ex_imm, 32'h10);
        check("cap_rs", ex_rs, 8);

        set_id(5'd9, 5'd9, 5'd10, 32'd4, 32'd4, 8'h11);
        wb_regwrite = 1'b1; wb_reg = 5'd9; wb_data = 32'hDEAD;
        tick();
        check("byp_a", ex_a, 32'hDEAD);
        check("byp_b", ex_b, 32'hDEAD);
        wb_reg = 5'd0;
        tick();
        check("byp_r0_a", ex_a, 4);
        id_rs = 5'd0; id_reg1 = 32'd5;
        tick();
        check("rs0_a", ex_a, 0);
        wb_regwrite = 1'b0;

        // load-use: lw rt=8, then consumer reads rs=8
        set_id(5'd1, 5'd8, 5'd0, 32'd1, 32'd1, 8'h03);
        tick();
        check("lw_dest", ex_dest, 8);
        set_id(5'd8, 5'd2, 5'd3, 32'd7, 32'd9, 8'h11);
        #1;
        check("lu_stall", stall, 1);
        tick();
        check("lu_bubble", ex_valid, 0);
        check("lu_bub_ctrl", ex_ctrl, 0);
        check("lu_stall_off", stall, 0);
        check("lu_count", stall_count, 1);
        tick();
        check("lu_held_valid", ex_valid, 1);
        check("lu_held_a", ex_a, 7);
        check("lu_held_dest", ex_dest, 3);
        check("lu_count2", stall_count, 1);

        set_id(5'd1, 5'd8, 5'd0, 32'd1, 32'd1, 8'h03);
        tick();
        set_id(5'd8, 5'd2, 5'd3, 32'd7, 32'd9, 8'h11);
        flush = 1'b1;
        #1;
        check("fl_stall", stall, 0);
        tick();
        flush = 1'b0;
        check("fl_bubble", ex_valid, 0);
        check("fl_count", stall_count, 1);

        set_id(5'd1, 5'd0, 5'd0, 32'd1, 32'd1, 8'h03);
        tick();
        check("ld0_memread", ex_ctrl, 8'h03);
        set_id(5'd0, 5'd0, 5'd3, 32'd7, 32'd9, 8'h11);
        #1;
        check("ld0_stall", stall, 0);

        for (int i = 0; i < 20; i++) begin
            set_id(5'd1, 5'd8, 5'd0, 32'd1, 32'd1, 8'h03);
            tick();
            set_id(5'd8, 5'd2, 5'd3, 32'd7, 32'd9, 8'h11);
            tick();
        end
        check("sat_count", stall_count, 15);
        set_id(5'd1, 5'd8, 5'd0, 32'd1, 32'd1, 8'h03);
        tick();
        set_id(5'd8, 5'd2, 5'd3, 32'd7, 32'd9, 8'h11);
        #1;
        check("sat_stall", stall, 1);
        tick();
        check("sat_hold", stall_count, 15);

        set_id(5'd1, 5'd8, 5'd0, 32'd1, 32'd1, 8'h03);
        tick();
        set_id(5'd8, 5'd2, 5'd3, 32'd7, 32'd9, 8'h11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_count", stall_count, 0);
        check("rst2_valid", ex_valid, 0);
        check("rst2_stall", stall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
